// File: rtl/pulse_handshake_tx.sv
// Source side of a four-phase req/ack pulse transfer. Each single-cycle event
// on pulse_in becomes one full req/ack round trip to a far clock domain. A
// one-deep pending buffer absorbs an event that arrives mid-handshake; further
// events are discarded and counted. A phase timer aborts a stalled handshake
// and raises a sticky error.
//
// Handshake contract: req rises to announce an event and stays high until the
// synchronized ack is seen high; req then falls and the block waits for the
// synchronized ack to fall, which completes the transfer (done pulses once).
module pulse_handshake_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 8,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk_a,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              ack_async,
  input  logic              err_clr,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic              drop,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // A one-flop synchronizer is never acceptable, so clamp the depth at two.
  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMAX = TW'(TLAST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_HI  = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [SS-1:0]   ack_sync;
  logic            ack_s;
  logic            pending, pend_nx;
  logic [TW-1:0]   timer;
  logic            tmo;
  logic            absorb;
  logic            done_nx, drop_nx, err_set;

  // Bring the far-domain ack level into clk_a; only the last stage is used.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SS-2:0], ack_async};
  end

  assign ack_s = ack_sync[SS-1];

  // The timer holds the number of cycles already spent in the current phase.
  assign tmo = (TIMEOUT != 0) && (state != IDLE) && (timer == TMAX);

  // Next state, pending buffer and one-cycle event decisions.
  always_comb begin
    state_nx = state;
    pend_nx  = pending;
    done_nx  = 1'b0;
    drop_nx  = 1'b0;
    err_set  = 1'b0;
    absorb   = 1'b1;
    case (state)
      IDLE: begin
        // Launch only when the far side has released ack; otherwise the
        // event waits in the pending slot.
        if ((pending || pulse_in) && !ack_s) begin
          state_nx = REQ_HI;
          pend_nx  = pending & pulse_in;
          absorb   = 1'b0;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          state_nx = WAIT_LO;
        end else if (tmo) begin
          state_nx = IDLE;
          err_set  = 1'b1;
          absorb   = 1'b0;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          // Completion: the pending event (or a fresh one) starts the next
          // round trip immediately; a fresh event alongside a pending one
          // takes the freed slot.
          done_nx = 1'b1;
          absorb  = 1'b0;
          if (pending || pulse_in) begin
            state_nx = REQ_HI;
            pend_nx  = pending & pulse_in;
          end else begin
            state_nx = IDLE;
          end
        end else if (tmo) begin
          state_nx = IDLE;
          err_set  = 1'b1;
          absorb   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        pend_nx  = 1'b0;
        absorb   = 1'b0;
      end
    endcase
    // An event that is not launched goes to the pending slot, or is
    // discarded when the slot is already occupied.
    if (absorb && pulse_in) begin
      if (pending) drop_nx = 1'b1;
      else         pend_nx = 1'b1;
    end
    // An aborted handshake also discards whatever was waiting.
    if (err_set) pend_nx = 1'b0;
  end

  // State, pending slot and registered outputs.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      req      <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pend_nx;
      req     <= (state_nx == REQ_HI);
      done    <= done_nx;
      drop    <= drop_nx;
      if (drop_nx && (drop_cnt != {DROP_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
      // A timeout wins over a clear arriving in the same cycle.
      err     <= err_set | (err & ~err_clr);
    end
  end

  // Phase timer restarts on every state change and idles at zero.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n)                                    timer <= '0;
    else if ((state_nx != state) || (state_nx == IDLE)) timer <= '0;
    else                                           timer <= timer + 1'b1;
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Bench for pulse_handshake_tx. The far side echoes req back as ack after a
// programmable number of clk_a cycles. The reference model works at the
// transaction level: with a fixed echo delay every round trip has a known
// length, so expected outputs follow from event times and a pending count.
module tb_pulse_handshake_tx;

  localparam int SYNC   = 2;
  localparam int DROP_W = 2;
  localparam int TMO    = 8;

  logic              clk_a = 1'b0;
  logic              rst_n = 1'b0;
  logic              pulse_in = 1'b0;
  logic              ack_async;
  logic              err_clr = 1'b0;
  logic              req, busy, done, drop, err;
  logic [DROP_W-1:0] drop_cnt;
  logic [1:0]        state_dbg;

  pulse_handshake_tx #(
    .SYNC_STAGES (SYNC),
    .DROP_W      (DROP_W),
    .TIMEOUT     (TMO)
  ) dut (
    .clk_a     (clk_a),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .ack_async (ack_async),
    .err_clr   (err_clr),
    .req       (req),
    .busy      (busy),
    .done      (done),
    .drop      (drop),
    .drop_cnt  (drop_cnt),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk_a = ~clk_a;

  // ---------------- far side ----------------
  logic [7:0] pipe = '0;
  int         far_d = 3;
  logic       far_en = 1'b1;

  always @(negedge clk_a) pipe <= {pipe[6:0], req};
  assign ack_async = far_en & pipe[far_d-1];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit model_on = 1'b0;
  int m_edge, m_start, m_done_at, m_cnt;
  bit m_active, m_pend, m_done, m_drop;
  int seen_done, seen_drop;

  function automatic int hs_len();
    return 2 * (far_d + SYNC);
  endfunction

  task automatic model_init();
    m_edge = 0; m_start = 0; m_done_at = 0; m_cnt = 0;
    m_active = 0; m_pend = 0; m_done = 0; m_drop = 0;
  endtask

  task automatic model_update(input logic p);
    int t;
    m_edge++;
    t = m_edge;
    m_done = 0;
    m_drop = 0;
    if (!m_active) begin
      if (p) begin
        m_active = 1; m_start = t; m_done_at = t + hs_len();
      end
    end else if (t == m_done_at) begin
      m_done = 1;
      if (m_pend || p) begin
        m_start = t; m_done_at = t + hs_len();
        m_pend = m_pend && p;
      end else begin
        m_active = 0;
      end
    end else if (p) begin
      if (m_pend) begin
        m_drop = 1;
        if (m_cnt < (1 << DROP_W) - 1) m_cnt++;
      end else begin
        m_pend = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clk_a);
    if (model_on) model_update(p);
    #1;
    if (done) seen_done++;
    if (drop) seen_drop++;
    if (model_on) begin
      check("req",  int'(req),  int'(m_active && ((m_edge - m_start) < far_d + SYNC)));
      check("busy", int'(busy), int'(m_active));
      check("done", int'(done), int'(m_done));
      check("drop", int'(drop), int'(m_drop));
      check("drop_cnt", int'(drop_cnt), m_cnt);
      check("err",  int'(err),  0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},  int'(req),  0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_drop"}, int'(drop), 0);
    check({tag, "_cnt"},  int'(drop_cnt), 0);
    check({tag, "_err"},  int'(err),  0);
  endtask

  task automatic do_reset();
    pulse_in = 0;
    err_clr  = 0;
    #2 rst_n = 0;
    repeat (10) @(posedge clk_a);
    #1 check_all_zero("reset");
    @(negedge clk_a);
    rst_n = 1;
    model_init();
    seen_done = 0;
    seen_drop = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    int          delay;
    logic [15:0] mask;
    int          req_edge;
    int          exp_done;
    int          exp_drop;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int first_req, req_hi, err_edge;

    vecs[0] = '{"single",    3, 16'h0001,  1, 1, 0, 0};
    vecs[1] = '{"three_mid", 3, 16'h001D,  1, 2, 2, 2};
    vecs[2] = '{"saturate",  3, 16'h03FF,  1, 2, 8, 3};
    vecs[3] = '{"chain",     3, 16'h0405, 11, 3, 0, 0};

    // Table-driven scenarios, each also cross-checked cycle by cycle.
    for (int v = 0; v < 4; v++) begin
      far_d  = vecs[v].delay;
      far_en = 1'b1;
      do_reset();
      model_on = 1'b1;
      for (int c = 0; c < 60; c++) begin
        step((c < 16) ? vecs[v].mask[c] : 1'b0);
        if (m_edge == vecs[v].req_edge) check({vecs[v].name, "_req_edge"}, int'(req), 1);
      end
      check({vecs[v].name, "_done_total"}, seen_done, vecs[v].exp_done);
      check({vecs[v].name, "_drop_total"}, seen_drop, vecs[v].exp_drop);
      check({vecs[v].name, "_cnt_final"},  int'(drop_cnt), vecs[v].exp_cnt);
      check({vecs[v].name, "_busy_end"},   int'(busy), 0);
    end

    // Timeout: far side silent, req must hold for TMO cycles then abort.
    model_on = 1'b0;
    far_d  = 3;
    far_en = 1'b0;
    do_reset();
    step(1'b1);
    req_hi = int'(req);
    err_edge = -1;
    for (int c = 2; c < 20; c++) begin
      step(1'b0);
      if (req) req_hi++;
      if (err && err_edge < 0) err_edge = c;
    end
    check("tmo_req_cycles", req_hi, TMO);
    check("tmo_err_edge", err_edge, TMO + 1);
    check("tmo_err", int'(err), 1);
    check("tmo_req_low", int'(req), 0);
    check("tmo_busy", int'(busy), 0);
    check("tmo_no_done", seen_done, 0);
    err_clr = 1'b1;
    step(1'b0);
    err_clr = 1'b0;
    check("err_clr", int'(err), 0);

    // Timeout in the same cycle as err_clr keeps the error.
    err_clr = 1'b1;
    step(1'b1);
    for (int c = 0; c < TMO; c++) step(1'b0);
    err_clr = 1'b0;
    check("tmo_vs_clr", int'(err), 1);
    step(1'b0);
    check("tmo_vs_clr_hold", int'(err), 1);

    // Reset while waiting for ack to fall: no done, then normal service.
    far_en = 1'b1;
    far_d  = 3;
    do_reset();
    step(1'b1);
    for (int c = 0; c < 7; c++) step(1'b0);
    check("wl_reached_busy", int'(busy), 1);
    check("wl_reached_req", int'(req), 0);
    #2 rst_n = 0;
    #1 check_all_zero("async_rst");
    repeat (10) @(posedge clk_a);
    #1 check("rst_no_done", seen_done, 0);
    @(negedge clk_a);
    rst_n = 1;
    model_init();
    model_on = 1'b1;
    first_req = -1;
    for (int c = 1; c <= 30; c++) begin
      step(c == 1);
      if (req && first_req < 0) first_req = c;
    end
    check("post_rst_req_edge", first_req, 1);
    check("post_rst_done", seen_done, 1);

    // Randomized traffic against the transaction-level model.
    for (int seg = 0; seg < 6; seg++) begin
      far_d = $urandom_range(1, 4);
      do_reset();
      model_on = 1'b1;
      for (int c = 0; c < 300; c++) step($urandom_range(0, 5) == 0);
      for (int c = 0; c < 30; c++) step(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
